// File: rtl/dac_pkg.sv
// Shared constants for the serial DAC and its surroundings.
package dac_pkg;
    localparam int  DAC_WIDTH     = 12;
    localparam real DAC_VREF      = 1.0;
    localparam int  CLK_PERIOD_NS = 10;
endpackage

// File: rtl/serial_dac.sv
// Serial-input DAC model: shifts a WIDTH-bit code in MSB-first while soc is high,
// then latches it and drives the ideal analog value on A_out.
module serial_dac
    import dac_pkg::*;
#(
    parameter int  WIDTH = DAC_WIDTH,
    parameter real VREF  = DAC_VREF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SI,
    input  logic             en,
    input  logic             soc,
    output real              A_out,
    output logic [WIDTH-1:0] code,
    output logic             eoc
);
    localparam int  CW    = $clog2(WIDTH);
    localparam real SCALE = VREF / (2.0 ** WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] nxt;
    logic [CW-1:0]    cnt;

    assign nxt = {sr[WIDTH-2:0], SI};

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            code  <= '0;
            A_out <= 0.0;
            eoc   <= 1'b0;
        end else if (!soc) begin
            // abort: drop any partial frame, keep the last completed result
            sr  <= '0;
            cnt <= '0;
            eoc <= 1'b0;
        end else if (!en) begin
            eoc <= 1'b0;
        end else if (cnt == CW'(WIDTH-1)) begin
            sr    <= nxt;
            cnt   <= '0;
            code  <= nxt;
            A_out <= real'(nxt) * SCALE;
            eoc   <= 1'b1;
        end else begin
            sr  <= nxt;
            cnt <= cnt + 1'b1;
            eoc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_dac.sv
// Directed bench for serial_dac: reset, full/mid-scale and streamed frames,
// abort, stall, mid-frame reset and soc dropping on the last bit.
module ClockGen
    import dac_pkg::*;
(
    output logic clk
);
    initial clk = 1'b0;
    always #(CLK_PERIOD_NS / 2) clk = ~clk;
endmodule

module tb_serial_dac;
    import dac_pkg::*;

    logic        clk;
    logic        rst;
    logic        SI;
    logic        en;
    logic        soc;
    real         A_out;
    logic [11:0] code;
    logic        eoc;

    int nchk = 0;
    int nerr = 0;

    ClockGen u_clk (.clk(clk));

    serial_dac dut (
        .clk  (clk),
        .rst  (rst),
        .SI   (SI),
        .en   (en),
        .soc  (soc),
        .A_out(A_out),
        .code (code),
        .eoc  (eoc)
    );

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        nchk++;
        assert (obs == exp)
        else begin
            nerr++;
            $error("FAIL %s: got %f expected %f", tag, obs, exp);
        end
    endtask

    // shift bits hi..lo of c; when bit 0 is taken the frame must complete
    task automatic shift_bits(input string tag, input logic [11:0] c,
                              input int hi, input int lo, input int prev_code);
        for (int i = hi; i >= lo; i--) begin
            SI = c[i];
            step();
            if (i > 0) begin
                chk({tag, " eoc low"}, int'(eoc), 0);
                chk({tag, " code hold"}, int'(code), prev_code);
            end else begin
                chk({tag, " eoc pulse"}, int'(eoc), 1);
                chk({tag, " code"}, int'(code), int'(c));
            end
        end
    endtask

    initial begin
        rst = 1'b1; soc = 1'b1; en = 1'b1; SI = 1'b1;
        repeat (3) step();
        chk("rst code", int'(code), 0);
        chk_r("rst A_out", A_out, 0.0);
        chk("rst eoc", int'(eoc), 0);
        chk("rst cnt", int'(dut.cnt), 0);
        rst = 1'b0;

        // full scale, then mid scale and LSB streamed back-to-back
        shift_bits("fs", 12'hFFF, 11, 0, 0);
        chk_r("fs A_out", A_out, 4095.0 / 4096.0);
        shift_bits("mid", 12'h800, 11, 0, 'hFFF);
        chk_r("mid A_out", A_out, 0.5);
        shift_bits("lsb", 12'h001, 11, 0, 'h800);
        chk_r("lsb A_out", A_out, 1.0 / 4096.0);

        // abort after 5 bits of 0xABC, en low too during the abort
        shift_bits("abc", 12'hABC, 11, 7, 'h001);
        soc = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort eoc", int'(eoc), 0);
            chk("abort code", int'(code), 'h001);
            chk("abort cnt", int'(dut.cnt), 0);
        end
        chk_r("abort A_out", A_out, 1.0 / 4096.0);
        soc = 1'b1; en = 1'b1;
        shift_bits("x123", 12'h123, 11, 0, 'h001);
        chk_r("x123 A_out", A_out, 291.0 / 4096.0);

        // stall mid-frame
        shift_bits("x5a5a", 12'h5A5, 11, 6, 'h123);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            SI = i[0];
            step();
            chk("stall eoc", int'(eoc), 0);
            chk("stall cnt", int'(dut.cnt), 6);
        end
        en = 1'b1;
        shift_bits("x5a5b", 12'h5A5, 5, 0, 'h123);
        chk_r("x5a5 A_out", A_out, 1445.0 / 4096.0);

        // reset mid-frame
        shift_bits("pre", 12'hFFF, 11, 6, 'h5A5);
        rst = 1'b1;
        step();
        chk("mrst code", int'(code), 0);
        chk_r("mrst A_out", A_out, 0.0);
        chk("mrst eoc", int'(eoc), 0);
        chk("mrst cnt", int'(dut.cnt), 0);
        rst = 1'b0;
        shift_bits("x0f0", 12'h0F0, 11, 0, 0);
        chk_r("x0f0 A_out", A_out, 240.0 / 4096.0);

        // soc drops on the edge that would take the last bit
        shift_bits("x333", 12'h333, 11, 1, 'h0F0);
        soc = 1'b0; SI = 1'b1;
        step();
        chk("lastdrop eoc", int'(eoc), 0);
        chk("lastdrop code", int'(code), 'h0F0);
        chk("lastdrop cnt", int'(dut.cnt), 0);
        chk_r("lastdrop A_out", A_out, 240.0 / 4096.0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
